// File: rtl/fetch_issue_unit.sv
// Fetch/issue stage: fetches 8-bit instructions, resolves jumps locally, drops illegal opcodes.
// Optional macro FETCH_RETIRE_CNT_EN adds a 16-bit retire_count output.
module fetch_issue_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [7:0]        imem_data,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [7:0]        instr,
  output logic [1:0]        opcode,
  output logic [ADDR_W-1:0] issue_pc,
`ifdef FETCH_RETIRE_CNT_EN
  output logic [15:0]       retire_count,
`endif
  output logic              illegal_instr
);

  typedef enum logic {S_FETCH = 1'b0, S_ISSUE = 1'b1} state_e;

  localparam logic [1:0] OP_JUMP    = 2'b11;
  localparam logic [1:0] OP_ILLEGAL = 2'b10;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        instr_q, instr_d;
  logic              illegal_q, illegal_d;

  logic              fetch_hit;
  logic              issue_hs;
  logic [ADDR_W-1:0] jump_off;

  assign fetch_hit = imem_req & imem_valid;
  assign issue_hs  = issue_valid & issue_ready;
  // Sign-extend the 6-bit jump field; the add below wraps modulo 2^ADDR_W.
  assign jump_off  = ADDR_W'($signed(instr_q[5:0]));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (fetch_hit && (imem_data[7:6] != OP_ILLEGAL)) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs; the request is gated by rst so it drops in the same cycle reset is asserted.
  always_comb begin
    imem_req      = rst & (state_q == S_FETCH) & fetch_en;
    imem_addr     = pc_q;
    issue_valid   = (state_q == S_ISSUE);
    issue_pc      = pc_q;
    instr         = instr_q;
    opcode        = instr_q[7:6];
    illegal_instr = illegal_q;
  end

  // Datapath next-state
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    if (fetch_hit) begin
      instr_d = imem_data;
      if (imem_data[7:6] == OP_ILLEGAL) begin
        illegal_d = 1'b1;
        pc_d      = pc_q + ADDR_W'(1);
      end
    end
    if (issue_hs) begin
      if (instr_q[7:6] == OP_JUMP) begin
        pc_d = pc_q + jump_off;
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      instr_q   <= 8'h00;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0] retire_q, retire_d;

  assign retire_d     = issue_hs ? retire_q + 16'd1 : retire_q;
  assign retire_count = retire_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_q <= 16'h0000;
    end else begin
      retire_q <= retire_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Scoreboard bench for fetch_issue_unit: expected issues and fetch addresses are queued per test.
module tb_fetch_issue_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_en;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid;
  logic [7:0] imem_data;
  logic       issue_valid;
  logic       issue_ready;
  logic [7:0] instr;
  logic [1:0] opcode;
  logic [7:0] issue_pc;
  logic       illegal_instr;
`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0] retire_count;
  logic [15:0] retire_model = 16'h0;
`endif

  always #5 clk = ~clk;

  fetch_issue_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_data    (imem_data),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .instr        (instr),
    .opcode       (opcode),
    .issue_pc     (issue_pc),
`ifdef FETCH_RETIRE_CNT_EN
    .retire_count (retire_count),
`endif
    .illegal_instr(illegal_instr)
  );

  // Zero-wait memory model with an optional address that never answers.
  logic [7:0] mem [256];
  logic       mem_en;
  logic       hold_en;
  logic [7:0] hold_addr;

  assign imem_valid = imem_req & mem_en & ~(hold_en & (imem_addr == hold_addr));
  assign imem_data  = mem[imem_addr];

  typedef struct {
    logic [7:0] ins;
    logic [7:0] pc;
  } iss_t;

  iss_t       iss_q[$];
  logic [7:0] fa_q[$];
  iss_t       mon_e;
  logic [7:0] mon_a;
  int         checks = 0;
  int         errors = 0;
  logic       seen_edge = 1'b0;

  always @(posedge clk) seen_edge <= 1'b1;

  // Scoreboard monitor: pops on each issue handshake and each completed fetch.
  always @(negedge clk) begin
    if (rst && issue_valid && issue_ready && iss_q.size() > 0) begin
      mon_e = iss_q.pop_front();
      checks++;
      if (instr !== mon_e.ins || issue_pc !== mon_e.pc || opcode !== mon_e.ins[7:6]) begin
        errors++;
        $display("FAIL issue: got instr=%h op=%b pc=%h, expected instr=%h op=%b pc=%h",
                 instr, opcode, issue_pc, mon_e.ins, mon_e.ins[7:6], mon_e.pc);
      end else begin
        $display("issue instr=%h op=%b pc=%h", instr, opcode, issue_pc);
      end
    end
    if (rst && imem_req && imem_valid && fa_q.size() > 0) begin
      mon_a = fa_q.pop_front();
      checks++;
      if (imem_addr !== mon_a) begin
        errors++;
        $display("FAIL fetch_addr: got %h, expected %h", imem_addr, mon_a);
      end else begin
        $display("fetch addr=%h data=%h", imem_addr, imem_data);
      end
    end
`ifdef FETCH_RETIRE_CNT_EN
    if (seen_edge) begin
      checks++;
      if (retire_count !== retire_model) begin
        errors++;
        $display("FAIL retire_count: got %0d, expected %0d", retire_count, retire_model);
      end
      if (!rst) retire_model = 16'h0;
      else if (issue_valid && issue_ready) retire_model = retire_model + 16'h1;
    end
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_reset();
    rst         = 1'b0;
    fetch_en    = 1'b1;
    issue_ready = 1'b1;
    mem_en      = 1'b1;
    hold_en     = 1'b0;
    hold_addr   = 8'h00;
    iss_q.delete();
    fa_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    tick();
    tick();
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (iss_q.size() == 0 && fa_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: %0d issues and %0d fetches outstanding, expected 0",
               name, iss_q.size(), fa_q.size());
      iss_q.delete();
      fa_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; fetch_en = 1'b1; issue_ready = 1'b1; mem_en = 1'b0; hold_en = 1'b0; hold_addr = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (imem_req !== 1'b0 || issue_valid !== 1'b0 || illegal_instr !== 1'b0 || instr !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold: req=%b valid=%b illegal=%b instr=%h, expected 0 0 0 00",
                 imem_req, issue_valid, illegal_instr, instr);
      end else begin
        $display("reset cycle %0d outputs idle", c);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: req=%b addr=%h, expected 1 00", imem_req, imem_addr);
    end else begin
      $display("reset release req=1 addr=00");
    end
  endtask

  task automatic test_sequential();
    enter_reset();
    mem[0] = 8'h5B; mem[1] = 8'h2A;
    iss_q.push_back('{8'h5B, 8'h00});
    iss_q.push_back('{8'h2A, 8'h01});
    fa_q.push_back(8'h00); fa_q.push_back(8'h01); fa_q.push_back(8'h02);
    rst = 1'b1;
    tick();
    checks++;
    if (issue_valid !== 1'b1 || instr !== 8'h5B) begin
      errors++;
      $display("FAIL seq_latency: valid=%b instr=%h, expected 1 5b", issue_valid, instr);
    end
    wait_drain(20, "seq");
  endtask

  // Backward jump, backward wrap past 0 and forward wrap past 0xFF.
  task automatic test_jump();
    enter_reset();
    mem[8'h00] = 8'hC5; mem[8'h05] = 8'hFD; mem[8'h02] = 8'hFC; mem[8'hFE] = 8'hC4;
    iss_q.push_back('{8'hC5, 8'h00});
    iss_q.push_back('{8'hFD, 8'h05});
    iss_q.push_back('{8'hFC, 8'h02});
    iss_q.push_back('{8'hC4, 8'hFE});
    fa_q.push_back(8'h00); fa_q.push_back(8'h05); fa_q.push_back(8'h02);
    fa_q.push_back(8'hFE); fa_q.push_back(8'h02);
    rst = 1'b1;
    wait_drain(40, "jump");
  endtask

  task automatic test_self_loop();
    enter_reset();
    mem[0] = 8'hC0;
    for (int i = 0; i < 3; i++) begin
      iss_q.push_back('{8'hC0, 8'h00});
      fa_q.push_back(8'h00);
    end
    rst = 1'b1;
    wait_drain(30, "selfloop");
  endtask

  task automatic test_backpressure();
    bit got = 1'b0;
    enter_reset();
    mem[0] = 8'h11;
    issue_ready = 1'b0;
    iss_q.push_back('{8'h11, 8'h00});
    fa_q.push_back(8'h00); fa_q.push_back(8'h01);
    rst = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = issue_valid;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bp_valid_timeout: issue_valid=%b, expected 1", issue_valid);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (issue_valid !== 1'b1 || instr !== 8'h11 || issue_pc !== 8'h00 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: valid=%b instr=%h pc=%h req=%b, expected 1 11 00 0",
                 issue_valid, instr, issue_pc, imem_req);
      end else begin
        $display("backpressure cycle %0d held", c);
      end
    end
    issue_ready = 1'b1;
    tick();
    checks++;
    if (issue_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h01) begin
      errors++;
      $display("FAIL bp_accept: valid=%b req=%b addr=%h, expected 0 1 01",
               issue_valid, imem_req, imem_addr);
    end
    wait_drain(20, "bp");
  endtask

  task automatic test_illegal();
    bit hit = 1'b0;
    enter_reset();
    mem[0] = 8'hC3; mem[3] = 8'h80; mem[4] = 8'h25;
    iss_q.push_back('{8'hC3, 8'h00});
    iss_q.push_back('{8'h25, 8'h04});
    fa_q.push_back(8'h00); fa_q.push_back(8'h03); fa_q.push_back(8'h04);
    rst = 1'b1;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (imem_req && imem_valid && imem_addr == 8'h03) begin
        hit = 1'b1;
        checks++;
        if (illegal_instr !== 1'b0) begin
          errors++;
          $display("FAIL illegal_early: flag=%b, expected 0", illegal_instr);
        end
      end
      tick();
    end
    checks++;
    if (!hit || illegal_instr !== 1'b1 || issue_valid !== 1'b0 || imem_addr !== 8'h04) begin
      errors++;
      $display("FAIL illegal_drop: hit=%b flag=%b valid=%b addr=%h, expected 1 1 0 04",
               hit, illegal_instr, issue_valid, imem_addr);
    end else begin
      $display("illegal 80 dropped, next addr=04");
    end
    wait_drain(20, "illegal");
    fetch_en = 1'b0;
    repeat (4) tick();
    checks++;
    if (illegal_instr !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: flag=%b, expected 1", illegal_instr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (illegal_instr !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: flag=%b, expected 0", illegal_instr);
    end
  endtask

  task automatic test_reset_mid();
    bit waiting = 1'b0;
    enter_reset();
    mem[0] = 8'hC7; mem[7] = 8'h3D;
    hold_en = 1'b1; hold_addr = 8'h07;
    iss_q.push_back('{8'hC7, 8'h00});
    fa_q.push_back(8'h00);
    rst = 1'b1;
    for (int i = 0; i < 20 && !waiting; i++) begin
      tick();
      waiting = imem_req && (imem_addr == 8'h07);
    end
    tick(); tick();
    checks++;
    if (!waiting || imem_req !== 1'b1 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait: seen=%b req=%b valid=%b, expected 1 1 0", waiting, imem_req, issue_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_req_drop: req=%b, expected 0", imem_req);
    end
    tick();
    checks++;
    if (issue_valid !== 1'b0 || instr !== 8'h00 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_state: valid=%b instr=%h addr=%h, expected 0 00 00",
               issue_valid, instr, imem_addr);
    end
    mem[0] = 8'h01;
    iss_q.delete();
    fa_q.delete();
    iss_q.push_back('{8'h01, 8'h00});
    fa_q.push_back(8'h00);
    rst = 1'b1;
    wait_drain(20, "mid");
  endtask

  initial begin
    rst = 1'b0; fetch_en = 1'b0; issue_ready = 1'b0;
    mem_en = 1'b0; hold_en = 1'b0; hold_addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_sequential();
    test_jump();
    test_self_loop();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_issue_unit.md
Name: fetch_issue_unit

Overview:
- Instruction fetch stage directly upstream of the main control decoder.
- Holds the program counter and fetches 8-bit instructions from instruction memory over a req/valid handshake.
- Presents one instruction at a time, with its opcode field, to the decode/control stage over a valid/ready handshake.
- Resolves jump instructions internally by redirecting the PC. Drops and flags illegal opcodes so they never reach decode.

Parameters:
- ADDR_W, 8, width of PC and instruction-memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-low.
- fetch_en  input  1  when low, no new fetch request is started.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  ADDR_W  fetch address; equals pc.
- imem_valid  input  1  imem_data valid this cycle; ignored unless imem_req=1.
- imem_data  input  8  fetched instruction.
- issue_valid  output  1  instruction on instr/opcode/issue_pc is valid.
- issue_ready  input  1  downstream accepts the instruction.
- instr  output  8  issued instruction word.
- opcode  output  2  instr[7:6], feeds the control decoder.
- issue_pc  output  ADDR_W  address of the issued instruction.
- illegal_instr  output  1  sticky flag: an opcode 2'b10 was fetched.

Behaviour:
Instruction format:
- [7:6] opcode.
- 00 load-immediate: rd=[5:4], imm=[3:0].
- 01 add: rd=[5:4], rs1=[3:2], rs2=[1:0].
- 11 jump: signed 6-bit PC-relative offset in [5:0].
- 10 illegal.

Reset (rst=0 at a clock edge):
- pc=RESET_PC, state=FETCH.
- instr=8'h00, issue_valid=0, illegal_instr=0.
- imem_req is forced 0 in every cycle rst=0.
- Reset overrides everything, including an outstanding request or a pending issue; no instruction is issued or retired in that cycle.

FSM states FETCH and ISSUE:
- FETCH: imem_req = fetch_en (combinational), imem_addr = pc.
  - On a cycle with imem_req=1 and imem_valid=1: capture imem_data into instr.
  - If imem_data[7:6]==2'b10: set illegal_instr=1, pc<=pc+1, remain in FETCH (instruction not issued).
  - Otherwise go to ISSUE.
  - Zero-wait memory is allowed: valid may arrive in the same cycle the request is raised.
  - fetch_en falling while waiting deasserts imem_req; a valid seen while req=0 is ignored.
- ISSUE: issue_valid=1, imem_req=0. instr, opcode and issue_pc are held stable until the handshake.
  - On issue_valid & issue_ready: if opcode==2'b11, pc <= pc + sign_extend(instr[5:0]); else pc <= pc+1. Then go to FETCH.

Output and arithmetic rules:
- issue_valid is registered: asserted the cycle after valid capture, deasserted the cycle after acceptance.
- issue_pc = pc while in ISSUE.
- All PC arithmetic is modulo 2^ADDR_W (wrap both directions).
- A jump offset of 0 is a legal self-loop.
- Throughput: at most one instruction per 2 cycles. Minimum latency from imem_valid to issue_valid is 1 cycle.
- illegal_instr is cleared only by reset.

Optional Feature:
- Macro FETCH_RETIRE_CNT_EN.
- Defined: adds output port retire_count (16 bits).
  - Reset value 0.
  - Increments by 1 on each issue handshake (issue_valid & issue_ready).
  - Wraps from 16'hFFFF to 0.
  - Illegal, dropped instructions are not counted.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with fetch_en=1 → imem_req=0, issue_valid=0, illegal_instr=0. On the first cycle after release, imem_req=1 and imem_addr=0x00.
- Sequential issue: mem[0]=0x5B, mem[1]=0x2A, zero-wait memory, issue_ready=1.
  - Issues instr 0x5B (opcode 01, issue_pc 0x00), then 0x2A (opcode 00, issue_pc 0x01).
  - Fetch addresses are 0x00, 0x01, 0x02.
- Jump: at pc 0x05, instr 0xFD (offset -3) → next imem_addr 0x02. Forward wrap: at pc 0xFE, instr 0xC4 (offset +4) → next imem_addr 0x02.
- Backpressure: issue_ready=0 for 5 cycles while in ISSUE → issue_valid=1, instr/issue_pc unchanged, imem_req=0 throughout. Acceptance follows on the cycle ready rises.
- Illegal: mem[3]=0x80 → never issued; illegal_instr=1 from the following cycle; next imem_addr 0x04; flag persists until reset.
- Reset mid-operation: with imem_req=1 and imem_valid withheld at pc 0x07, assert rst=0 → imem_req=0 immediately. After release, fetch resumes at 0x00 and no stale instruction is issued.
